mem_arbiter: RTL

- Two-port arbiter/sequencer in front of the 16-bit byte-addressable split even/odd memory.
- Shares the memory between the instruction-fetch requester and the data (LDB/LDW/STB/STW) requester.
- Holds each access stable for a fixed number of cycles, then returns a one-cycle acknowledge with read data.
- Rejects misaligned word accesses without touching memory.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, port ids and
// the word/byte select seen by the split even/odd memory.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_D  = 1'b1;

   localparam logic MEM_WORD = 1'b1;
   localparam logic MEM_BYTE = 1'b0;

   // A word access must start on an even byte address.
   function automatic logic is_misaligned(input logic word, input logic addr_lsb);
      return word & addr_lsb;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the port that did not win last time
// is chosen. last_grant starts at DATA so fetch wins the first tie.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic if_req_i,
   input  logic d_req_i,
   input  logic take_i,
   output logic valid_o,
   output logic grant_o
);

   logic last_grant_q;

   always_comb begin
      valid_o = if_req_i | d_req_i;
      grant_o = GRANT_IF;
      if (if_req_i && d_req_i) begin
         grant_o = (last_grant_q == GRANT_IF) ? GRANT_D : GRANT_IF;
      end else if (d_req_i) begin
         grant_o = GRANT_D;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= GRANT_D;
      end else if (take_i && valid_o) begin
         last_grant_q <= grant_o;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences fetch and data accesses onto one memory: grant in IDLE, hold the
// address/control for LATENCY cycles in ACCESS, acknowledge for one cycle in DONE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   input  logic              d_word,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write_n,
   output logic              mem_word,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int         BYTE_W   = DATA_W / 2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_word_q, mem_word_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic idle;
   logic arb_valid;
   logic arb_grant;

   assign idle = (state_q == ST_IDLE);

   rr_arb2 u_rr_arb2 (
      .clk      (clk),
      .rst      (reset),
      .if_req_i (if_req),
      .d_req_i  (d_req),
      .take_i   (idle),
      .valid_o  (arb_valid),
      .grant_o  (arb_grant)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      we_d        = we_q;
      err_d       = err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_word_d  = mem_word_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d = arb_grant;
               if (arb_grant == GRANT_D && is_misaligned(d_word, d_addr[0])) begin
                  // Rejected without touching the memory interface.
                  err_d   = 1'b1;
                  we_d    = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = CNT_INIT;
                  state_d = ST_ACCESS;
                  if (arb_grant == GRANT_IF) begin
                     mem_addr_d = if_addr;
                     mem_word_d = MEM_WORD;
                     we_d       = 1'b0;
                  end else begin
                     mem_addr_d = d_addr;
                     mem_word_d = d_word ? MEM_WORD : MEM_BYTE;
                     we_d       = d_we;
                     if (d_we) begin
                        mem_wdata_d = d_word ? d_wdata : {2{d_wdata[BYTE_W-1:0]}};
                     end
                  end
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  if (grant_q == GRANT_IF) begin
                     if_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         grant_q     <= GRANT_IF;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_word_q  <= MEM_WORD;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         err_q       <= err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_word_q  <= mem_word_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // The single write cycle is the last ACCESS cycle of a store.
   assign mem_write_n = !((state_q == ST_ACCESS) && (cnt_q == 4'd0) && we_q);
   assign if_ack      = (state_q == ST_DONE) && (grant_q == GRANT_IF);
   assign d_ack       = (state_q == ST_DONE) && (grant_q == GRANT_D);
   assign d_err       = d_ack && err_q;
   assign busy        = !idle;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_word    = mem_word_q;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;

endmodule
